// File: rtl/mfp_ahb_seg_arbiter_if.sv
// AHB-Lite segment bus between the segment arbiter (master) and the segment slave.
// Carries only the transfer signals; clock and reset stay plain ports.
interface mfp_ahb_seg_arbiter_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADY, HRESP
    );
endinterface

// File: rtl/mfp_ahb_seg_arbiter.sv
// Round-robin arbiter sharing the 7-segment register set between two requesters;
// writes only the changed EN/MSB/LSB/DP registers with single non-pipelined AHB-Lite writes.
module mfp_ahb_seg_arbiter #(
    parameter logic [31:0] SEG_BASE  = 32'h1F70_0000,
    parameter logic [3:0]  OFF_EN    = 4'h0,
    parameter logic [3:0]  OFF_MSB   = 4'h4,
    parameter logic [3:0]  OFF_LSB   = 4'h8,
    parameter logic [3:0]  OFF_DP    = 4'hC,
    parameter bit          FORCE_ALL = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  en0,
    input  logic [7:0]  en1,
    input  logic [63:0] dig0,
    input  logic [63:0] dig1,
    input  logic [7:0]  dp0,
    input  logic [7:0]  dp1,
    output logic        ack0,
    output logic        ack1,
    output logic        err,
    output logic        busy,
    mfp_ahb_seg_arbiter_if.master ahb
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned EW = 8;
    localparam int unsigned GW = 64;
    localparam int unsigned NR = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [1:0] IDX_EN  = 2'd0;
    localparam logic [1:0] IDX_MSB = 2'd1;
    localparam logic [1:0] IDX_LSB = 2'd2;
    localparam logic [1:0] IDX_DP  = 2'd3;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    typedef struct packed {
        logic [EW-1:0] en;
        logic [GW-1:0] dig;
        logic [EW-1:0] dp;
    } seg_img_t;

    // Shadow reset value matches the slave's register reset values.
    localparam seg_img_t SH_RESET = '{en: 8'hFF, dig: 64'h0, dp: 8'hFF};

    state_t        state_q, state_d;
    seg_img_t      img_q, img_d;
    seg_img_t      sh_q, sh_d;
    logic [NR-1:0] dirty_q, dirty_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          err_flag_q, err_flag_d;
    logic [AW-1:0] haddr_q, haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic          hwrite_q, hwrite_d;
    logic [DW-1:0] hwdata_q, hwdata_d;
    logic          ack0_d, ack1_d, err_d, busy_d;
    logic          gnt_new;
    logic [1:0]    sel_cur, sel_nxt;

    // Lowest set dirty bit gives the fixed EN, MSB, LSB, DP service order.
    function automatic logic [1:0] first_dirty(input logic [NR-1:0] d);
        first_dirty = IDX_EN;
        for (int i = NR - 1; i >= 0; i--) begin
            if (d[i]) first_dirty = 2'(i);
        end
    endfunction

    function automatic logic [3:0] reg_offset(input logic [1:0] s);
        case (s)
            IDX_EN:  reg_offset = OFF_EN;
            IDX_MSB: reg_offset = OFF_MSB;
            IDX_LSB: reg_offset = OFF_LSB;
            default: reg_offset = OFF_DP;
        endcase
    endfunction

    function automatic logic [DW-1:0] reg_value(input seg_img_t im, input logic [1:0] s);
        case (s)
            IDX_EN:  reg_value = DW'(im.en);
            IDX_MSB: reg_value = im.dig[GW-1:DW];
            IDX_LSB: reg_value = im.dig[DW-1:0];
            default: reg_value = DW'(im.dp);
        endcase
    endfunction

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= IDLE;
            img_q      <= '0;
            sh_q       <= SH_RESET;
            dirty_q    <= '0;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            err_flag_q <= 1'b0;
            haddr_q    <= '0;
            htrans_q   <= HTRANS_IDLE;
            hwrite_q   <= 1'b0;
            hwdata_q   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            img_q      <= img_d;
            sh_q       <= sh_d;
            dirty_q    <= dirty_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            err_flag_q <= err_flag_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hwdata_q   <= hwdata_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            err        <= err_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        img_d      = img_q;
        sh_d       = sh_q;
        dirty_d    = dirty_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        err_flag_d = err_flag_q;
        haddr_d    = haddr_q;
        hwdata_d   = hwdata_q;
        htrans_d   = HTRANS_IDLE;
        hwrite_d   = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        err_d      = 1'b0;
        gnt_new    = last_q;
        sel_cur    = first_dirty(dirty_q);

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_new = (req0 && req1) ? ~last_q : req1;
                    gnt_d   = gnt_new;
                    last_d  = gnt_new;
                    img_d   = gnt_new ? seg_img_t'({en1, dig1, dp1})
                                      : seg_img_t'({en0, dig0, dp0});
                    if (FORCE_ALL) begin
                        dirty_d = '1;
                    end else begin
                        dirty_d = {img_d.dp != sh_q.dp,
                                   img_d.dig[DW-1:0] != sh_q.dig[DW-1:0],
                                   img_d.dig[GW-1:DW] != sh_q.dig[GW-1:DW],
                                   img_d.en != sh_q.en};
                    end
                    state_d = (dirty_d != '0) ? ADDR : DONE;
                end
            end
            ADDR: begin
                if (ahb.HREADY) state_d = DATA;
            end
            DATA: begin
                if (ahb.HREADY) begin
                    if (!ahb.HRESP) begin
                        case (sel_cur)
                            IDX_EN:  sh_d.en            = img_q.en;
                            IDX_MSB: sh_d.dig[GW-1:DW]  = img_q.dig[GW-1:DW];
                            IDX_LSB: sh_d.dig[DW-1:0]   = img_q.dig[DW-1:0];
                            default: sh_d.dp            = img_q.dp;
                        endcase
                        dirty_d[sel_cur] = 1'b0;
                        state_d = (dirty_d != '0) ? ADDR : DONE;
                    end else begin
                        err_flag_d = 1'b1;
                        dirty_d    = '0;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                err_flag_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered, so they are derived from the state being entered.
        sel_nxt = first_dirty(dirty_d);
        if (state_d == ADDR) begin
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b1;
            haddr_d  = SEG_BASE + AW'(reg_offset(sel_nxt));
        end
        if (state_d == DATA) hwdata_d = reg_value(img_d, sel_nxt);
        if (state_d == DONE) begin
            ack0_d = ~gnt_d;
            ack1_d = gnt_d;
            err_d  = err_flag_d;
        end
        busy_d = (state_d != IDLE);
    end

    assign ahb.HADDR  = haddr_q;
    assign ahb.HTRANS = htrans_q;
    assign ahb.HWRITE = hwrite_q;
    assign ahb.HSIZE  = HSIZE_WORD;
    assign ahb.HWDATA = hwdata_q;

endmodule
